// File: rtl/t08_fetch_ras.sv
// t08 fetch unit: PC generation, PC-relative redirects and a circular return-address stack.
// Optional build macro T08_FETCH_MISALIGN_EN: misaligned redirect targets are refused and flagged.
module t08_fetch_ras #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         freeze,
    input  logic                         jump,
    input  logic                         branch,
    input  logic                         ret,
    input  logic [XLEN-1:0]              imm_offset,
    output logic [XLEN-1:0]              program_counter,
    output logic [XLEN-1:0]              ret_address,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow,
    output logic                         misalign_err
);

    localparam int              PTR_W    = $clog2(RAS_DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [XLEN-1:0]  INC_X    = XLEN'(INC);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             unf_q;

    logic [XLEN-1:0]  seq_pc;
    logic [XLEN-1:0]  rel_target;
    logic [XLEN-1:0]  ras_top;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  next_pc;
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic             ras_empty;
    logic             ras_full;
    logic             redirect;

    // wr_ptr names the next free slot; the top entry sits one below it, circularly.
    assign top_ptr    = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_W'(1);
    assign wr_ptr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
    assign ras_empty  = (cnt_q == '0);
    assign ras_full   = (cnt_q == CNT_FULL);
    assign ras_top    = ras_mem[top_ptr];
    assign seq_pc     = pc_q + INC_X;
    assign rel_target = pc_q + imm_offset;

    always_comb begin
        redirect = 1'b0;
        target   = seq_pc;
        if (jump) begin
            redirect = 1'b1;
            target   = rel_target;
        end else if (ret) begin
            if (!ras_empty) begin
                redirect = 1'b1;
                target   = ras_top;
            end
        end else if (branch) begin
            redirect = 1'b1;
            target   = rel_target;
        end
    end

`ifdef T08_FETCH_MISALIGN_EN
    logic misaligned;
    logic mis_q;

    assign misaligned = redirect && (target[1:0] != 2'b00);
    assign next_pc    = misaligned ? seq_pc : target;

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= !freeze && misaligned;
        end
    end

    assign misalign_err = mis_q;
`else
    assign next_pc      = target;
    assign misalign_err = 1'b0;
`endif

    // Stack bookkeeping follows the command even when a misaligned target is refused.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            wr_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
        end else if (!freeze) begin
            pc_q <= next_pc;
            if (jump) begin
                ras_mem[wr_ptr] <= seq_pc;
                wr_ptr          <= wr_ptr_inc;
                if (ras_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (ret) begin
                if (ras_empty) begin
                    unf_q <= 1'b1;
                end else begin
                    wr_ptr <= top_ptr;
                    cnt_q  <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign program_counter = pc_q;
    assign ret_address     = ras_empty ? '0 : ras_top;
    assign ras_count       = cnt_q;
    assign ras_overflow    = ovf_q;
    assign ras_underflow   = unf_q;

endmodule
